// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with writeback bypass, load-use stall and ID/EX register.
// Register-file addresses and the bypass mux are combinational; everything else lands one cycle later.
module id_stage (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_inst_i,
    input  logic [31:0] if_pc_i,
    input  logic        flush_i,
    output logic        if_stall_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_w_data_i,
    input  logic        wb_w_en_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_rs1_val_o,
    output logic [31:0] id_rs2_val_o,
    output logic [31:0] id_imm_o,
    output logic [4:0]  id_rs1_addr_o,
    output logic [4:0]  id_rs2_addr_o,
    output logic [4:0]  id_rd_addr_o,
    output logic [6:0]  id_opcode_o,
    output logic [2:0]  id_funct3_o,
    output logic        id_funct7b5_o,
    output logic        id_reg_write_o,
    output logic        id_mem_read_o,
    output logic        id_mem_write_o,
    output logic        id_illegal_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic        legal, use_rs1, use_rs2, hazard, bubble;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [31:0] rs1_byp, rs2_byp;

    logic        id_valid_d, id_valid_q;
    logic [31:0] id_pc_d, id_pc_q;
    logic [31:0] id_rs1_val_d, id_rs1_val_q;
    logic [31:0] id_rs2_val_d, id_rs2_val_q;
    logic [31:0] id_imm_d, id_imm_q;
    logic [4:0]  id_rs1_addr_d, id_rs1_addr_q;
    logic [4:0]  id_rs2_addr_d, id_rs2_addr_q;
    logic [4:0]  id_rd_addr_d, id_rd_addr_q;
    logic [6:0]  id_opcode_d, id_opcode_q;
    logic [2:0]  id_funct3_d, id_funct3_q;
    logic        id_funct7b5_d, id_funct7b5_q;
    logic        id_reg_write_d, id_reg_write_q;
    logic        id_mem_read_d, id_mem_read_q;
    logic        id_mem_write_d, id_mem_write_q;
    logic        id_illegal_d, id_illegal_q;

    assign opcode = if_inst_i[6:0];
    assign rd     = if_inst_i[11:7];
    assign rs1    = if_inst_i[19:15];
    assign rs2    = if_inst_i[24:20];

    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_branch = opcode == OP_BRANCH;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_opimm  = opcode == OP_OPIMM;
    assign is_op     = opcode == OP_OP;

    assign legal   = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
    assign use_rs1 = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
    assign use_rs2 = is_branch | is_store | is_op;

    assign imm_i = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
    assign imm_s = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
    assign imm_b = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0};
    assign imm_u = {if_inst_i[31:12], 12'b0};
    assign imm_j = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0};

    assign imm = (is_jalr | is_load | is_opimm) ? imm_i :
                 is_store                       ? imm_s :
                 is_branch                      ? imm_b :
                 (is_lui | is_auipc)            ? imm_u :
                 is_jal                         ? imm_j : 32'b0;

    // x0 never takes the bypass, so a writeback aimed at x0 cannot leak into a read of x0
    assign rs1_byp = (rs1 == 5'd0) ? 32'b0 :
                     (wb_w_en_i && wb_rd_addr_i == rs1) ? wb_w_data_i : rs1_data_i;
    assign rs2_byp = (rs2 == 5'd0) ? 32'b0 :
                     (wb_w_en_i && wb_rd_addr_i == rs2) ? wb_w_data_i : rs2_data_i;

    assign hazard = id_valid_q & id_mem_read_q & (id_rd_addr_q != 5'd0) & if_valid_i &
                    ((use_rs1 & (rs1 == id_rd_addr_q)) | (use_rs2 & (rs2 == id_rd_addr_q)));
    assign bubble = flush_i | hazard;

    assign if_stall_o = hazard & ~flush_i & ~reset_i;

    always_comb begin
        id_valid_d     = if_valid_i & ~bubble;
        id_pc_d        = if_pc_i;
        id_rs1_val_d   = use_rs1 ? rs1_byp : 32'b0;
        id_rs2_val_d   = use_rs2 ? rs2_byp : 32'b0;
        id_imm_d       = imm;
        id_rs1_addr_d  = use_rs1 ? rs1 : 5'd0;
        id_rs2_addr_d  = use_rs2 ? rs2 : 5'd0;
        id_rd_addr_d   = rd;
        id_opcode_d    = opcode;
        id_funct3_d    = if_inst_i[14:12];
        id_funct7b5_d  = if_inst_i[30];
        id_reg_write_d = ~bubble & (rd != 5'd0) &
                         (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op);
        id_mem_read_d  = ~bubble & is_load;
        id_mem_write_d = ~bubble & is_store;
        id_illegal_d   = ~legal;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            id_valid_q     <= 1'b0;
            id_pc_q        <= '0;
            id_rs1_val_q   <= '0;
            id_rs2_val_q   <= '0;
            id_imm_q       <= '0;
            id_rs1_addr_q  <= '0;
            id_rs2_addr_q  <= '0;
            id_rd_addr_q   <= '0;
            id_opcode_q    <= '0;
            id_funct3_q    <= '0;
            id_funct7b5_q  <= 1'b0;
            id_reg_write_q <= 1'b0;
            id_mem_read_q  <= 1'b0;
            id_mem_write_q <= 1'b0;
            id_illegal_q   <= 1'b0;
        end else begin
            id_valid_q     <= id_valid_d;
            id_pc_q        <= id_pc_d;
            id_rs1_val_q   <= id_rs1_val_d;
            id_rs2_val_q   <= id_rs2_val_d;
            id_imm_q       <= id_imm_d;
            id_rs1_addr_q  <= id_rs1_addr_d;
            id_rs2_addr_q  <= id_rs2_addr_d;
            id_rd_addr_q   <= id_rd_addr_d;
            id_opcode_q    <= id_opcode_d;
            id_funct3_q    <= id_funct3_d;
            id_funct7b5_q  <= id_funct7b5_d;
            id_reg_write_q <= id_reg_write_d;
            id_mem_read_q  <= id_mem_read_d;
            id_mem_write_q <= id_mem_write_d;
            id_illegal_q   <= id_illegal_d;
        end
    end

    assign id_valid_o     = id_valid_q;
    assign id_pc_o        = id_pc_q;
    assign id_rs1_val_o   = id_rs1_val_q;
    assign id_rs2_val_o   = id_rs2_val_q;
    assign id_imm_o       = id_imm_q;
    assign id_rs1_addr_o  = id_rs1_addr_q;
    assign id_rs2_addr_o  = id_rs2_addr_q;
    assign id_rd_addr_o   = id_rd_addr_q;
    assign id_opcode_o    = id_opcode_q;
    assign id_funct3_o    = id_funct3_q;
    assign id_funct7b5_o  = id_funct7b5_q;
    assign id_reg_write_o = id_reg_write_q;
    assign id_mem_read_o  = id_mem_read_q;
    assign id_mem_write_o = id_mem_write_q;
    assign id_illegal_o   = id_illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, if_valid, flush, wb_w_en;
    logic [31:0] if_inst, if_pc, rs1_data, rs2_data, wb_w_data;
    logic [4:0]  wb_rd_addr;
    logic        if_stall;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        id_valid, id_funct7b5, id_reg_write, id_mem_read, id_mem_write, id_illegal;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clock_i(clk), .reset_i(rst), .if_valid_i(if_valid), .if_inst_i(if_inst), .if_pc_i(if_pc),
        .flush_i(flush), .if_stall_o(if_stall), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .wb_rd_addr_i(wb_rd_addr),
        .wb_w_data_i(wb_w_data), .wb_w_en_i(wb_w_en), .id_valid_o(id_valid), .id_pc_o(id_pc),
        .id_rs1_val_o(id_rs1_val), .id_rs2_val_o(id_rs2_val), .id_imm_o(id_imm),
        .id_rs1_addr_o(id_rs1_addr), .id_rs2_addr_o(id_rs2_addr), .id_rd_addr_o(id_rd_addr),
        .id_opcode_o(id_opcode), .id_funct3_o(id_funct3), .id_funct7b5_o(id_funct7b5),
        .id_reg_write_o(id_reg_write), .id_mem_read_o(id_mem_read), .id_mem_write_o(id_mem_write),
        .id_illegal_o(id_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b1; if_inst = 32'hFFF00093; if_pc = 32'h40; flush = 1'b0;
        wb_w_en = 1'b0; wb_rd_addr = 5'd0; wb_w_data = 32'h0; rs1_data = 32'h5555AAAA; rs2_data = 32'h0;
        tick(); tick();
        vec++; if (id_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %h exp 0", id_valid); end
        vec++; if (if_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %h exp 0", if_stall); end
        vec++; if ({id_pc, id_imm, id_rs1_val, id_rs2_val} !== 128'h0) begin errs++; $display("FAIL reset_data got %h %h %h %h exp 0", id_pc, id_imm, id_rs1_val, id_rs2_val); end
        vec++; if ({id_rd_addr, id_rs1_addr, id_rs2_addr, id_opcode, id_funct3, id_funct7b5, id_reg_write, id_mem_read, id_mem_write, id_illegal} !== 30'h0) begin errs++; $display("FAIL reset_ctrl got rd=%h op=%h rw=%b ill=%b exp 0", id_rd_addr, id_opcode, id_reg_write, id_illegal); end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        if_inst = 32'hFFF00093; if_pc = 32'h100; rs1_data = 32'h12345678;
        #1;
        vec++; if (rs2_addr !== 5'd31) begin errs++; $display("FAIL decode_rs2_addr got %0d exp 31", rs2_addr); end
        tick();
        vec++; if (id_imm !== 32'hFFFFFFFF) begin errs++; $display("FAIL decode_imm got %h exp ffffffff", id_imm); end
        vec++; if (id_rs1_val !== 32'h0) begin errs++; $display("FAIL decode_rs1_val got %h exp 0", id_rs1_val); end
        vec++; if ({id_valid, id_rd_addr, id_reg_write, id_illegal} !== {1'b1, 5'd1, 1'b1, 1'b0}) begin errs++; $display("FAIL decode_ctrl got v=%b rd=%0d rw=%b ill=%b exp 1 1 1 0", id_valid, id_rd_addr, id_reg_write, id_illegal); end
        vec++; if ({id_pc, id_opcode, id_rs2_addr} !== {32'h100, 7'h13, 5'd0}) begin errs++; $display("FAIL decode_fields got pc=%h op=%h rs2a=%0d exp 100 13 0", id_pc, id_opcode, id_rs2_addr); end
    endtask

    task automatic test_bypass();
        if_inst = 32'h00028333; wb_w_en = 1'b1; wb_rd_addr = 5'd5; wb_w_data = 32'hDEADBEEF;
        rs1_data = 32'h11111111; rs2_data = 32'h22222222;
        #1;
        vec++; if ({rs1_addr, rs2_addr} !== {5'd5, 5'd0}) begin errs++; $display("FAIL bypass_addrs got %0d %0d exp 5 0", rs1_addr, rs2_addr); end
        tick();
        vec++; if (id_rs1_val !== 32'hDEADBEEF) begin errs++; $display("FAIL bypass_rs1 got %h exp deadbeef", id_rs1_val); end
        vec++; if (id_rs2_val !== 32'h0) begin errs++; $display("FAIL bypass_x0 got %h exp 0", id_rs2_val); end
        wb_rd_addr = 5'd0;
        tick();
        vec++; if (id_rs1_val !== 32'h11111111) begin errs++; $display("FAIL bypass_wb0_rs1 got %h exp 11111111", id_rs1_val); end
        vec++; if (id_rs2_val !== 32'h0) begin errs++; $display("FAIL bypass_wb0_x0 got %h exp 0", id_rs2_val); end
        if_inst = 32'h00728333; wb_rd_addr = 5'd7;
        tick();
        vec++; if ({id_rs1_val, id_rs2_val} !== {32'h11111111, 32'hDEADBEEF}) begin errs++; $display("FAIL bypass_rs2 got %h %h exp 11111111 deadbeef", id_rs1_val, id_rs2_val); end
        vec++; if ({id_imm, id_rs2_addr, id_rd_addr} !== {32'h0, 5'd7, 5'd6}) begin errs++; $display("FAIL rtype_fields got imm=%h rs2a=%0d rd=%0d exp 0 7 6", id_imm, id_rs2_addr, id_rd_addr); end
        wb_w_en = 1'b0;
    endtask

    task automatic test_load_use();
        if_inst = 32'h00012183;
        tick();
        vec++; if ({id_valid, id_mem_read, id_rd_addr, id_rs1_addr} !== {1'b1, 1'b1, 5'd3, 5'd2}) begin errs++; $display("FAIL lw_issue got v=%b mr=%b rd=%0d rs1a=%0d exp 1 1 3 2", id_valid, id_mem_read, id_rd_addr, id_rs1_addr); end
        if_inst = 32'h00118233; wb_w_en = 1'b1; wb_rd_addr = 5'd3; wb_w_data = 32'hCAFEF00D;
        #1;
        vec++; if (if_stall !== 1'b1) begin errs++; $display("FAIL loaduse_stall got %b exp 1", if_stall); end
        tick();
        wb_w_en = 1'b0;
        #1;
        vec++; if ({id_valid, id_reg_write, id_mem_read, id_mem_write} !== 4'b0) begin errs++; $display("FAIL loaduse_bubble got v=%b rw=%b mr=%b mw=%b exp 0", id_valid, id_reg_write, id_mem_read, id_mem_write); end
        vec++; if (if_stall !== 1'b0) begin errs++; $display("FAIL loaduse_release got %b exp 0", if_stall); end
        tick();
        vec++; if ({id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write} !== {1'b1, 5'd3, 5'd1, 5'd4, 1'b1}) begin errs++; $display("FAIL loaduse_add got v=%b rs1a=%0d rs2a=%0d rd=%0d rw=%b exp 1 3 1 4 1", id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write); end
    endtask

    task automatic test_flush();
        if_inst = 32'h00012183;
        tick();
        if_inst = 32'h00118233; flush = 1'b1;
        #1;
        vec++; if (if_stall !== 1'b0) begin errs++; $display("FAIL flush_stall got %b exp 0", if_stall); end
        tick();
        flush = 1'b0;
        vec++; if ({id_valid, id_reg_write} !== 2'b00) begin errs++; $display("FAIL flush_valid got v=%b rw=%b exp 0 0", id_valid, id_reg_write); end
        if_inst = 32'h00012183;
        tick();
        if_inst = 32'h00118233;
        #1;
        vec++; if (if_stall !== 1'b1) begin errs++; $display("FAIL midstall_pre got %b exp 1", if_stall); end
        rst = 1'b1;
        #1;
        vec++; if (if_stall !== 1'b0) begin errs++; $display("FAIL midstall_reset_stall got %b exp 0", if_stall); end
        tick();
        vec++; if ({id_valid, id_pc, id_rd_addr, id_mem_read} !== 39'h0) begin errs++; $display("FAIL midstall_reset_regs got v=%b pc=%h rd=%0d mr=%b exp 0", id_valid, id_pc, id_rd_addr, id_mem_read); end
        rst = 1'b0;
    endtask

    task automatic test_branch_illegal();
        if_inst = 32'hFE000EE3;
        tick();
        vec++; if ({id_imm, id_reg_write, id_illegal} !== {32'hFFFFFFFC, 1'b0, 1'b0}) begin errs++; $display("FAIL beq got imm=%h rw=%b ill=%b exp fffffffc 0 0", id_imm, id_reg_write, id_illegal); end
        if_inst = 32'h0000007F;
        tick();
        vec++; if ({id_illegal, id_reg_write, id_mem_read, id_mem_write} !== 4'b1000) begin errs++; $display("FAIL illegal got ill=%b rw=%b mr=%b mw=%b exp 1 0 0 0", id_illegal, id_reg_write, id_mem_read, id_mem_write); end
        if_inst = 32'hFE712C23;
        tick();
        vec++; if ({id_imm, id_mem_write, id_reg_write, id_rs2_addr} !== {32'hFFFFFFF8, 1'b1, 1'b0, 5'd7}) begin errs++; $display("FAIL store got imm=%h mw=%b rw=%b rs2a=%0d exp fffffff8 1 0 7", id_imm, id_mem_write, id_reg_write, id_rs2_addr); end
        if_inst = 32'h123450B7;
        tick();
        vec++; if ({id_imm, id_reg_write, id_rs1_addr} !== {32'h12345000, 1'b1, 5'd0}) begin errs++; $display("FAIL lui got imm=%h rw=%b rs1a=%0d exp 12345000 1 0", id_imm, id_reg_write, id_rs1_addr); end
        if_inst = 32'h0000006F;
        tick();
        vec++; if ({id_reg_write, id_illegal, id_imm} !== {1'b0, 1'b0, 32'h0}) begin errs++; $display("FAIL jal_x0 got rw=%b ill=%b imm=%h exp 0 0 0", id_reg_write, id_illegal, id_imm); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bypass();
        test_load_use();
        test_flush();
        test_branch_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
